// File: rtl/bcd_threshold_monitor_pkg.sv
// -----------------------------------------------------------------------------
// bcd_threshold_monitor_pkg
// Shared types and constants for the BCD threshold monitor:
//   state_t    - sequencer states (IDLE / CONV / DONE)
//   BCD_W      - bits per packed BCD digit
//   MAX_DIGIT  - largest legal BCD digit value
// -----------------------------------------------------------------------------
package bcd_threshold_monitor_pkg;

    localparam int BCD_W     = 4;
    localparam int MAX_DIGIT = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_threshold_monitor_mac.sv
// -----------------------------------------------------------------------------
// bcd_digit_mac
// Purely combinational digit step of the BCD-to-binary conversion:
// next = acc*10 + digit, saturated to 2^BIN_W-1.
// Ports:
//   i_acc       [BIN_W+4] running accumulator (never above 2^BIN_W-1)
//   i_digit     [BCD_W]   current BCD digit
//   o_acc_next  [BIN_W+4] updated accumulator, saturated on overflow
//   o_digit_err           digit is not a legal BCD value
//   o_overflow            unsaturated result exceeded 2^BIN_W-1
// -----------------------------------------------------------------------------
module bcd_digit_mac
    import bcd_threshold_monitor_pkg::*;
#(
    parameter int BIN_W = 10
) (
    input  logic [BIN_W+3:0] i_acc,
    input  logic [BCD_W-1:0] i_digit,
    output logic [BIN_W+3:0] o_acc_next,
    output logic             o_digit_err,
    output logic             o_overflow
);

    // Four extra bits over the accumulator cover acc*10+15 with no wrap.
    localparam int PW = BIN_W + 8;

    logic [PW-1:0] w_prod;

    assign w_prod      = PW'(i_acc) * PW'(10) + PW'(i_digit);
    assign o_overflow  = |w_prod[PW-1:BIN_W];
    // Saturating keeps the accumulator bounded so later steps cannot wrap.
    assign o_acc_next  = o_overflow ? (BIN_W+4)'({BIN_W{1'b1}}) : w_prod[BIN_W+3:0];
    assign o_digit_err = (i_digit > BCD_W'(MAX_DIGIT));

endmodule

// File: rtl/bcd_threshold_monitor.sv
// -----------------------------------------------------------------------------
// bcd_threshold_monitor
// Converts a packed BCD sample to binary one digit per cycle (MSD first) and
// drives a low-level alarm with hysteresis against per-sample thresholds.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a sample; accept latches bcd/thresholds, clears acc
// CONV  | one digit per cycle; down-counter marks the last digit
// DONE  | out_valid pulse; results and alarm were loaded on entry
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_in_valid     sample/thresholds valid     o_in_ready   high only in IDLE
//   i_bcd_in       packed BCD, MSD in top nibble
//   i_thr_lo       alarm set threshold         i_thr_hi     alarm clear threshold
//   o_out_valid    one-cycle result strobe     o_bin_out    converted value
//   o_bcd_err      illegal digit seen          o_ovf        value above 2^BIN_W-1
//   o_alarm        registered hysteretic alarm
// -----------------------------------------------------------------------------
module bcd_threshold_monitor
    import bcd_threshold_monitor_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [BCD_W*DIGITS-1:0] i_bcd_in,
    input  logic [BIN_W-1:0]        i_thr_lo,
    input  logic [BIN_W-1:0]        i_thr_hi,
    output logic                    o_out_valid,
    output logic [BIN_W-1:0]        o_bin_out,
    output logic                    o_bcd_err,
    output logic                    o_ovf,
    output logic                    o_alarm
);

    localparam int BCD_BITS = BCD_W * DIGITS;
    localparam int ACC_W    = BIN_W + 4;
    localparam int CNT_W    = $clog2(DIGITS + 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [BCD_BITS-1:0]  r_bcd;
    logic [BIN_W-1:0]     r_thr_lo;
    logic [BIN_W-1:0]     r_thr_hi;
    logic [ACC_W-1:0]     r_acc;
    logic                 r_err;
    logic                 r_ovf;
    logic [CNT_W-1:0]     r_cnt;
    logic [BIN_W-1:0]     r_bin_out;
    logic                 r_bcd_err;
    logic                 r_ovf_out;
    logic                 r_alarm;

    logic                 w_accept;
    logic                 w_last;
    logic [BCD_W-1:0]     w_digit;
    logic [ACC_W-1:0]     w_acc_next;
    logic                 w_digit_err;
    logic                 w_mac_ovf;
    logic                 w_err_final;
    logic                 w_ovf_final;
    logic [BIN_W-1:0]     w_result;

    // The sample register shifts left each digit, so the MSD is always on top.
    assign w_digit = r_bcd[BCD_BITS-1 -: BCD_W];

    bcd_digit_mac #(
        .BIN_W (BIN_W)
    ) u_mac (
        .i_acc       (r_acc),
        .i_digit     (w_digit),
        .o_acc_next  (w_acc_next),
        .o_digit_err (w_digit_err),
        .o_overflow  (w_mac_ovf)
    );

    assign w_accept    = i_in_valid && o_in_ready;
    assign w_last      = (r_cnt == '0);
    assign w_err_final = r_err | w_digit_err;
    assign w_ovf_final = r_ovf | w_mac_ovf;
    assign w_result    = w_ovf_final ? {BIN_W{1'b1}} : w_acc_next[BIN_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_in_ready   = 1'b0;
        o_out_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_state_next = ST_CONV;
                end
            end
            ST_CONV: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_out_valid  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd     <= '0;
            r_thr_lo  <= '0;
            r_thr_hi  <= '0;
            r_acc     <= '0;
            r_err     <= 1'b0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
            r_bin_out <= '0;
            r_bcd_err <= 1'b0;
            r_ovf_out <= 1'b0;
            r_alarm   <= 1'b0;
        end else if (w_accept) begin
            r_bcd    <= i_bcd_in;
            r_thr_lo <= i_thr_lo;
            r_thr_hi <= i_thr_hi;
            r_acc    <= '0;
            r_err    <= 1'b0;
            r_ovf    <= 1'b0;
            r_cnt    <= CNT_W'(DIGITS - 1);
        end else if (r_state == ST_CONV) begin
            r_bcd <= r_bcd << BCD_W;
            r_acc <= w_acc_next;
            r_err <= w_err_final;
            r_ovf <= w_ovf_final;
            if (!w_last) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end else begin
                // Results and alarm load on the edge entering DONE, so they
                // are valid together with out_valid and hold until next DONE.
                r_bcd_err <= w_err_final;
                r_ovf_out <= w_ovf_final & ~w_err_final;
                r_bin_out <= w_err_final ? '0 : w_result;
                if (!w_err_final) begin
                    // Set is tested first so it wins when thresholds overlap.
                    if (w_result <= r_thr_lo) begin
                        r_alarm <= 1'b1;
                    end else if (w_result >= r_thr_hi) begin
                        r_alarm <= 1'b0;
                    end
                end
            end
        end
    end

    assign o_bin_out = r_bin_out;
    assign o_bcd_err = r_bcd_err;
    assign o_ovf     = r_ovf_out;
    assign o_alarm   = r_alarm;

endmodule

// File: tb/tb_bcd_threshold_monitor.sv
module tb_bcd_threshold_monitor;

    typedef struct {
        int bin;
        bit err;
        bit ovf;
        bit alarm;
        int cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid [2];
    logic [15:0] bcd      [2];
    logic [9:0]  lo       [2];
    logic [9:0]  hi       [2];
    logic        ready    [2];
    logic        ovalid   [2];
    logic [9:0]  bin      [2];
    logic        err      [2];
    logic        ovf      [2];
    logic        alarm    [2];

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb [2][$];
    exp_t e_mon;
    bit   model_alarm [2];
    bit   stream      [2];
    int   stream_prev [2];
    int   acc_cnt     [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_threshold_monitor #(.DIGITS(3), .BIN_W(10)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid[0]), .o_in_ready(ready[0]),
        .i_bcd_in(bcd[0][11:0]), .i_thr_lo(lo[0]), .i_thr_hi(hi[0]),
        .o_out_valid(ovalid[0]), .o_bin_out(bin[0]), .o_bcd_err(err[0]),
        .o_ovf(ovf[0]), .o_alarm(alarm[0])
    );

    bcd_threshold_monitor #(.DIGITS(4), .BIN_W(10)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(in_valid[1]), .o_in_ready(ready[1]),
        .i_bcd_in(bcd[1]), .i_thr_lo(lo[1]), .i_thr_hi(hi[1]),
        .o_out_valid(ovalid[1]), .o_bin_out(bin[1]), .o_bcd_err(err[1]),
        .o_ovf(ovf[1]), .o_alarm(alarm[1])
    );

    function automatic int nd(input int k);
        return (k == 0) ? 3 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Reference: decimal value of the digits, saturating at 1023, plus alarm.
    function automatic exp_t model(input int k, input logic [15:0] v,
                                   input logic [9:0] l, input logic [9:0] h);
        exp_t e;
        int a = 0;
        int d;
        e.err = 1'b0;
        e.ovf = 1'b0;
        for (int i = nd(k) - 1; i >= 0; i--) begin
            d = int'((v >> (4 * i)) & 16'hF);
            if (d > 9) e.err = 1'b1;
            a = a * 10 + d;
            if (a > 1023) begin
                e.ovf = 1'b1;
                a = 1023;
            end
        end
        if (e.err) begin
            e.bin = 0;
            e.ovf = 1'b0;
        end else begin
            e.bin = a;
            if (a <= int'(l)) model_alarm[k] = 1'b1;
            else if (a >= int'(h)) model_alarm[k] = 1'b0;
        end
        e.alarm = model_alarm[k];
        e.cyc   = cyc;
        return e;
    endfunction

    function automatic logic [15:0] rand_bcd(input int n);
        logic [15:0] r = '0;
        for (int i = 0; i < n; i++) begin
            r[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                       : 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    // Scoreboard: push on accept, pop and compare on out_valid.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                sb[k].delete();
                model_alarm[k] = 1'b0;
                stream_prev[k] = -1;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!stream[k]) stream_prev[k] = -1;
                if (in_valid[k] && ready[k]) begin
                    if (stream_prev[k] >= 0)
                        chk($sformatf("accept_gap[%0d]", k), cyc - stream_prev[k], nd(k) + 2);
                    if (stream[k]) stream_prev[k] = cyc;
                    acc_cnt[k]++;
                    sb[k].push_back(model(k, bcd[k], lo[k], hi[k]));
                end
                if (ovalid[k]) begin
                    chk($sformatf("out_valid_expected[%0d]", k), 32'(sb[k].size() > 0), 1);
                    if (sb[k].size() > 0) begin
                        e_mon = sb[k].pop_front();
                        chk($sformatf("bin_out[%0d]", k), bin[k], e_mon.bin);
                        chk($sformatf("bcd_err[%0d]", k), err[k], e_mon.err);
                        chk($sformatf("ovf[%0d]", k), ovf[k], e_mon.ovf);
                        chk($sformatf("alarm[%0d]", k), alarm[k], e_mon.alarm);
                        chk($sformatf("latency[%0d]", k), cyc - e_mon.cyc, nd(k) + 1);
                    end
                end
            end
        end
    end

    task automatic wait_drain();
        int n = 0;
        while ((sb[0].size() != 0 || sb[1].size() != 0 || !ready[0] || !ready[1]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb[0].size() + sb[1].size(), 0);
    endtask

    task automatic send(input int k, input logic [15:0] v, input logic [9:0] l,
                        input logic [9:0] h, input bit drain);
        int n = 0;
        @(posedge clk); #1;
        in_valid[k] = 1'b1;
        bcd[k] = v;
        lo[k]  = l;
        hi[k]  = h;
        @(negedge clk);
        while (!ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready[k]) chk($sformatf("accept_timeout[%0d]", k), ready[k], 1);
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        bcd[k] = 16'($urandom);
        lo[k]  = 10'($urandom);
        hi[k]  = 10'($urandom);
        if (drain) wait_drain();
    endtask

    task automatic check_reset(input int k);
        chk($sformatf("rst_out_valid[%0d]", k), ovalid[k], 0);
        chk($sformatf("rst_bin_out[%0d]", k), bin[k], 0);
        chk($sformatf("rst_bcd_err[%0d]", k), err[k], 0);
        chk($sformatf("rst_ovf[%0d]", k), ovf[k], 0);
        chk($sformatf("rst_alarm[%0d]", k), alarm[k], 0);
    endtask

    initial begin
        int base;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0;
            bcd[k] = '0;
            lo[k] = '0;
            hi[k] = '0;
            stream[k] = 1'b0;
            stream_prev[k] = -1;
            acc_cnt[k] = 0;
            model_alarm[k] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset(0);
        check_reset(1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset[0]", ready[0], 1);
        chk("ready_after_reset[1]", ready[1], 1);

        send(0, 16'h060, 10'd60, 10'd65, 1'b1);
        send(0, 16'h064, 10'd60, 10'd65, 1'b1);
        send(0, 16'h065, 10'd60, 10'd65, 1'b1);
        send(0, 16'h999, 10'd60, 10'd65, 1'b1);
        repeat (6) @(negedge clk);
        chk("hold_bin_out", bin[0], 999);
        chk("hold_out_valid", ovalid[0], 0);
        send(0, 16'h050, 10'd60, 10'd65, 1'b1);
        send(0, 16'h0A5, 10'd60, 10'd65, 1'b1);
        send(0, 16'h060, 10'd70, 10'd50, 1'b1);
        send(0, 16'h070, 10'd60, 10'd65, 1'b1);
        send(0, 16'h000, 10'd0,  10'd5,  1'b1);

        send(1, 16'h1024, 10'd1023, 10'd1023, 1'b1);
        send(1, 16'h0500, 10'd100,  10'd200,  1'b1);
        send(1, 16'h9999, 10'd0,    10'd1023, 1'b1);
        send(1, 16'hF999, 10'd1023, 10'd1023, 1'b1);

        @(posedge clk); #1;
        stream[0] = 1'b1;
        base = acc_cnt[0];
        @(posedge clk); #1;
        in_valid[0] = 1'b1;
        bcd[0] = rand_bcd(3);
        repeat (30) begin
            @(posedge clk); #1;
            bcd[0] = rand_bcd(3);
            lo[0]  = 10'($urandom_range(0, 999));
            hi[0]  = 10'($urandom_range(0, 999));
        end
        in_valid[0] = 1'b0;
        wait_drain();
        chk("stream_accepts", acc_cnt[0] - base, 6);
        stream[0] = 1'b0;

        send(0, 16'h123, 10'd500, 10'd600, 1'b0);
        @(posedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check_reset(0);
        check_reset(1);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_valid_after_abort", ovalid[0], 0);
        end
        send(0, 16'h042, 10'd10, 10'd20, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bcd_threshold_monitor.md
BCD_THRESHOLD_MONITOR -- requirements
Module: bcd_threshold_monitor

Interface
REQ-001 The block SHALL have parameter DIGITS, default 3, giving the number of BCD digits in bcd_in (range 1..8).
REQ-002 The block SHALL have parameter BIN_W, default 10, giving the binary result width (range 4..32).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  bcd_in, thr_lo and thr_hi are valid this cycle.
REQ-006 in_ready  output  1  the block accepts a sample this cycle.
REQ-007 bcd_in  input  4*DIGITS  packed BCD value; the most significant digit is in the top nibble.
REQ-008 thr_lo  input  BIN_W  alarm set threshold, unsigned.
REQ-009 thr_hi  input  BIN_W  alarm clear threshold, unsigned.
REQ-010 out_valid  output  1  one-cycle pulse marking bin_out, bcd_err and ovf as valid.
REQ-011 bin_out  output  BIN_W  converted binary value.
REQ-012 bcd_err  output  1  the accepted sample contained a digit greater than 9.
REQ-013 ovf  output  1  the converted value exceeded 2^BIN_W-1.
REQ-014 alarm  output  1  registered low-level alarm with hysteresis.

Function
REQ-015 The FSM SHALL have three states: IDLE, CONV and DONE.
- IDLE to CONV on in_valid && in_ready.
- CONV to DONE after DIGITS digit cycles.
- DONE to IDLE unconditionally.
REQ-016 in_ready SHALL be 1 only in IDLE.
- On accept: latch bcd_in, thr_lo and thr_hi.
- Clear the accumulator and the error and overflow flags.
REQ-017 CONV SHALL process one digit per cycle, most significant digit first, computing acc = acc*10 + digit.
- acc is BIN_W+4 bits wide internally.
REQ-018 Latency: out_valid SHALL assert exactly DIGITS+1 cycles after the accept edge, for one cycle, in state DONE.
REQ-019 A digit greater than 9 SHALL set a sticky bcd_err for the sample.
- When bcd_err=1 at DONE: bin_out=0, ovf=0, alarm unchanged.
REQ-020 If acc exceeds 2^BIN_W-1 at any digit step, ovf SHALL be set sticky.
- bin_out then saturates to all-ones.
- The alarm is still evaluated on the saturated value.
REQ-021 Alarm SHALL update only on the edge that raises out_valid.
- Set when bin_out <= thr_lo.
- Clear when bin_out >= thr_hi.
- Hold otherwise.
REQ-022 If thr_lo >= thr_hi and both conditions hold, set SHALL win (alarm=1).
REQ-023 bin_out, bcd_err and ovf SHALL hold their values until the next DONE.
REQ-024 Input changes outside the accept cycle SHALL have no effect.

Reset
REQ-025 While rst_n=0, the block SHALL hold these values:
- state IDLE
- in_ready 1 after release
- out_valid, bin_out, bcd_err, ovf, alarm and acc all 0
REQ-026 Reset asserted mid-CONV SHALL abort the conversion with no out_valid pulse.
- The first accept after release starts a fresh conversion.

Structure
REQ-027 The shared package SHALL hold the FSM state enum, BCD_W=4 and MAX_DIGIT=9.
REQ-028 The multiply-accumulate SHALL be a sub-module, bcd_digit_mac.
- Inputs: acc, digit.
- Outputs: next acc, digit_err, overflow.
- It SHALL be purely combinational, with one instance.

Verification
REQ-029 DIGITS=3, BIN_W=10, thr_lo=60, thr_hi=65, bcd_in=0x060 -> 4 cycles later out_valid=1, bin_out=60, alarm=1.
REQ-030 Then bcd_in=0x064 -> bin_out=64, alarm stays 1; then 0x065 -> bin_out=65, alarm=0; then 0x999 -> bin_out=999, alarm=0.
REQ-031 bcd_in=0x0A5 -> bcd_err=1, bin_out=0, alarm unchanged.
REQ-032 DIGITS=4, BIN_W=10, bcd_in=0x1024 -> ovf=1, bin_out=1023; with thr_lo=1023 -> alarm=1.
REQ-033 Pull rst_n low 2 cycles after accepting 0x123 -> no out_valid, all outputs 0; next 0x042 -> bin_out=42 at the required latency.
REQ-034 Hold in_valid=1 continuously -> accepts only in IDLE, one sample every DIGITS+2 cycles, no samples dropped or duplicated.
